// File: rtl/ibex_sram_port_arbiter.sv
// Shares one 1-cycle-latency single-port SRAM between the Ibex fetch and data ports.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed data-first priority.
module ibex_sram_port_arbiter #(
  parameter logic [31:0] MemBase   = 32'h0000_0000,
  parameter int unsigned MemDepth  = 16384,
  parameter int unsigned DataWidth = 33,
  parameter int unsigned AddrWidth = $clog2(MemDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 instr_req_i,
  output logic                 instr_gnt_o,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_rvalid_o,
  output logic [DataWidth-1:0] instr_rdata_o,
  output logic                 instr_err_o,

  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic                 data_err_o,

  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [3:0]           ram_be_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  input  logic [DataWidth-1:0] ram_rdata_i
);

  localparam logic [32:0] MemBytes = 33'(MemDepth) << 2;

  localparam logic [1:0] OwnNone  = 2'd0;
  localparam logic [1:0] OwnInstr = 2'd1;
  localparam logic [1:0] OwnData  = 2'd2;

  logic [1:0]  owner_q, owner_d;
  logic        err_q, err_d;
  logic        active_q;
  logic        en;
  logic [31:0] instr_off, data_off;
  logic        instr_in, data_in;
  logic        pick_data;
  logic        gnt_instr, gnt_data;
  logic [DataWidth-1:0] wdata_tagged;

  // Grants stay low during reset and for the first cycle after release.
  assign en = rst_ni & active_q;

  assign instr_off = instr_addr_i - MemBase;
  assign data_off  = data_addr_i - MemBase;
  assign instr_in  = {1'b0, instr_off} < MemBytes;
  assign data_in   = {1'b0, data_off} < MemBytes;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic contended;
  logic last_data_q;  // 1: data won the most recent contended cycle

  assign contended = instr_req_i & data_req_i;
  assign pick_data = contended ? ~last_data_q : data_req_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_data_q <= 1'b0;
    end else if (en && contended) begin
      last_data_q <= pick_data;
    end
  end
`else
  assign pick_data = data_req_i;
`endif

  assign gnt_data  = en & data_req_i & pick_data;
  assign gnt_instr = en & instr_req_i & ~pick_data;

  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  always_comb begin
    wdata_tagged = data_wdata_i;
    // Partial writes cannot carry a valid capability, so the tag is dropped.
    if (data_be_i != 4'hF) begin
      wdata_tagged[DataWidth-1] = 1'b0;
    end
  end

  always_comb begin
    ram_req_o   = (gnt_data & data_in) | (gnt_instr & instr_in);
    ram_we_o    = gnt_data & data_in & data_we_i;
    ram_be_o    = 4'hF;
    ram_wdata_o = '0;
    ram_addr_o  = data_off[AddrWidth+1:2];
    if (gnt_instr) begin
      ram_addr_o = instr_off[AddrWidth+1:2];
    end else if (gnt_data) begin
      ram_be_o    = data_be_i;
      ram_wdata_o = wdata_tagged;
    end
  end

  always_comb begin
    owner_d = OwnNone;
    err_d   = 1'b0;
    if (gnt_data) begin
      owner_d = OwnData;
      err_d   = ~data_in;
    end else if (gnt_instr) begin
      owner_d = OwnInstr;
      err_d   = ~instr_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      owner_q  <= OwnNone;
      err_q    <= 1'b0;
    end else begin
      active_q <= 1'b1;
      owner_q  <= owner_d;
      err_q    <= err_d;
    end
  end

  // Gating with rst_ni drops a pending response as soon as reset is asserted.
  assign instr_rvalid_o = rst_ni & (owner_q == OwnInstr);
  assign data_rvalid_o  = rst_ni & (owner_q == OwnData);
  assign instr_err_o    = instr_rvalid_o & err_q;
  assign data_err_o     = data_rvalid_o & err_q;
  assign instr_rdata_o  = (instr_rvalid_o & ~err_q) ? ram_rdata_i : '0;
  assign data_rdata_o   = (data_rvalid_o & ~err_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ibex_sram_port_arbiter.sv
// Directed bench for ibex_sram_port_arbiter with a behavioural 1-cycle SRAM.
module tb_ibex_sram_port_arbiter;

  localparam int unsigned Depth = 16384;
  localparam int unsigned DW    = 33;
  localparam int unsigned AW    = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0]   instr_addr;
  logic [DW-1:0] instr_rdata;
  logic          data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0]    data_be;
  logic [31:0]   data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          ram_req, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibex_sram_port_arbiter #(
    .MemBase  (32'h0000_0000),
    .MemDepth (Depth),
    .DataWidth(DW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_req_i   (instr_req),
    .instr_gnt_o   (instr_gnt),
    .instr_addr_i  (instr_addr),
    .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o (instr_rdata),
    .instr_err_o   (instr_err),
    .data_req_i    (data_req),
    .data_gnt_o    (data_gnt),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .data_err_o    (data_err),
    .ram_req_o     (ram_req),
    .ram_we_o      (ram_we),
    .ram_be_o      (ram_be),
    .ram_addr_o    (ram_addr),
    .ram_wdata_o   (ram_wdata),
    .ram_rdata_i   (ram_rdata)
  );

  // SRAM model: byte-lane writes, tag written on every write, read data one cycle later.
  logic [DW-1:0] mem [Depth];
  logic [DW-1:0] sram_w;
  logic          preloaded = 1'b0;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
      mem[0]    <= 33'h0_1111_0000;
      mem[1]    <= 33'h1_2222_0001;
      mem[2]    <= 33'h0_3333_0002;
      mem[4]    <= 33'h0_0000_0013;
      ram_rdata <= '0;
      preloaded <= 1'b1;
    end else if (ram_req) begin
      if (ram_we) begin
        sram_w = mem[ram_addr];
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) sram_w[8*b +: 8] = ram_wdata[8*b +: 8];
        end
        sram_w[32]     = ram_wdata[32];
        mem[ram_addr] <= sram_w;
        ram_rdata     <= '0;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic          ir;
    logic [31:0]   ia;
    logic          dr;
    logic          dwe;
    logic [3:0]    dbe;
    logic [31:0]   da;
    logic [DW-1:0] dwd;
    logic          eig;
    logic          edg;
    logic          erq;
    logic          erwe;
    logic [AW-1:0] era;
    logic [3:0]    erbe;
    logic [DW-1:0] erwd;
    logic          eiv;
    logic          eie;
    logic [DW-1:0] eird;
    logic          edv;
    logic          ede;
    logic [DW-1:0] edrd;
  } vec_t;

  localparam int NV = 16;
  vec_t v [NV];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [DW-1:0] dwd);
    instr_req  = ir;
    instr_addr = ia;
    data_req   = dr;
    data_we    = dwe;
    data_be    = dbe;
    data_addr  = da;
    data_wdata = dwd;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ignt"}, DW'(instr_gnt), '0);
    chk({tag, ".dgnt"}, DW'(data_gnt), '0);
    chk({tag, ".rreq"}, DW'(ram_req), '0);
    chk({tag, ".ivld"}, DW'(instr_rvalid), '0);
    chk({tag, ".ierr"}, DW'(instr_err), '0);
    chk({tag, ".irdata"}, instr_rdata, '0);
    chk({tag, ".dvld"}, DW'(data_rvalid), '0);
    chk({tag, ".derr"}, DW'(data_err), '0);
    chk({tag, ".drdata"}, data_rdata, '0);
  endtask

  initial begin
    // ir ia dr dwe dbe da dwd | eig edg erq erwe era erbe erwd | eiv eie eird | edv ede edrd
    v[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 14'd4, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 33'h0};
    v[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 4'hF, 33'h0, 1'b1, 1'b0, 33'h0_0000_0013, 1'b0, 1'b0, 33'h0};
    v[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 33'h1_DEAD_BEEF,
              1'b0, 1'b1, 1'b1, 1'b1, 14'h40, 4'hF, 33'h1_DEAD_BEEF, 1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 33'h0};
    v[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 33'h0,
              1'b0, 1'b1, 1'b1, 1'b0, 14'h40, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b1, 1'b0, 33'h0};
    v[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h100, 33'h1_CAFE_1234,
              1'b0, 1'b1, 1'b1, 1'b1, 14'h40, 4'h3, 33'h0_CAFE_1234, 1'b0, 1'b0, 33'h0, 1'b1, 1'b0, 33'h1_DEAD_BEEF};
    v[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 33'h0,
              1'b0, 1'b1, 1'b1, 1'b0, 14'h40, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b1, 1'b0, 33'h0};
    v[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b1, 1'b0, 33'h0_DEAD_1234};
    v[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 33'h0,
              1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 33'h0};
    v[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'hFFFF_FFFC, 33'h0,
              1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b1, 1'b1, 33'h0};
    v[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0001_0004, 33'h1_FFFF_FFFF,
              1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b1, 1'b1, 33'h0};
    v[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h4, 33'h0,
              1'b0, 1'b1, 1'b1, 1'b0, 14'd1, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b1, 1'b1, 33'h0};
    v[11] = '{1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 14'd0, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b1, 1'b0, 33'h1_2222_0001};
    v[12] = '{1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 14'd1, 4'hF, 33'h0, 1'b1, 1'b0, 33'h0_1111_0000, 1'b0, 1'b0, 33'h0};
    v[13] = '{1'b1, 32'hB, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 14'd2, 4'hF, 33'h0, 1'b1, 1'b0, 33'h1_2222_0001, 1'b0, 1'b0, 33'h0};
    v[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 4'hF, 33'h0, 1'b1, 1'b0, 33'h0_3333_0002, 1'b0, 1'b0, 33'h0};
    v[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 4'hF, 33'h0, 1'b0, 1'b0, 33'h0, 1'b0, 1'b0, 33'h0};

    // Reset held with both requests active: everything quiet.
    rst_n = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 33'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk_quiet($sformatf("rst%0d", c));
    end
    // First cycle after release: still no grants.
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_quiet("rel");

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(v[i].ir, v[i].ia, v[i].dr, v[i].dwe, v[i].dbe, v[i].da, v[i].dwd);
      #1;
      chk($sformatf("v%0d.ignt", i), DW'(instr_gnt), DW'(v[i].eig));
      chk($sformatf("v%0d.dgnt", i), DW'(data_gnt), DW'(v[i].edg));
      chk($sformatf("v%0d.rreq", i), DW'(ram_req), DW'(v[i].erq));
      chk($sformatf("v%0d.rwe", i), DW'(ram_we), DW'(v[i].erwe));
      if (v[i].erq) begin
        chk($sformatf("v%0d.raddr", i), DW'(ram_addr), DW'(v[i].era));
        chk($sformatf("v%0d.rbe", i), DW'(ram_be), DW'(v[i].erbe));
        chk($sformatf("v%0d.rwdata", i), ram_wdata, v[i].erwd);
      end
      chk($sformatf("v%0d.ivld", i), DW'(instr_rvalid), DW'(v[i].eiv));
      chk($sformatf("v%0d.ierr", i), DW'(instr_err), DW'(v[i].eie));
      chk($sformatf("v%0d.irdata", i), instr_rdata, v[i].eird);
      chk($sformatf("v%0d.dvld", i), DW'(data_rvalid), DW'(v[i].edv));
      chk($sformatf("v%0d.derr", i), DW'(data_err), DW'(v[i].ede));
      chk($sformatf("v%0d.drdata", i), data_rdata, v[i].edrd);
    end

    // Both ports held for 4 cycles, then data drops.
    for (int c = 0; c < 5; c++) begin
      logic exp_d;
      @(negedge clk);
      drive(1'b1, 32'h0, (c < 4), 1'b0, 4'hF, 32'h8, 33'h0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_d = (c < 4) && (c % 2 == 0);
`else
      exp_d = (c < 4);
`endif
      #1;
      chk($sformatf("cont%0d.dgnt", c), DW'(data_gnt), DW'(exp_d));
      chk($sformatf("cont%0d.ignt", c), DW'(instr_gnt), DW'(!exp_d));
      chk($sformatf("cont%0d.raddr", c), DW'(ram_addr), exp_d ? DW'(2) : DW'(0));
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0);
    #1;
    chk("cont.ivld", DW'(instr_rvalid), DW'(1));
    chk("cont.irdata", instr_rdata, 33'h0_1111_0000);

    // Reset asserted the cycle after a data read grant: response is dropped.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8, 33'h0);
    #1 chk("mid.dgnt", DW'(data_gnt), DW'(1));
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8, 33'h0);
    #1 chk_quiet("mid.rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_quiet("mid.rel");
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0);
    #1 chk_quiet("mid.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
